// File: rtl/control_sequencer_if.sv
// Sequencer pin bundle: pacing/step inputs, bus and flag inputs,
// advance strobe and control word outputs.
interface control_sequencer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
);
  logic                                 tick;
  logic                                 run_mode;
  logic                                 step_req;
  logic [DATA_WIDTH-1:0]                bus_in;
  logic                                 carry_in;
  logic                                 zero_in;
  logic                                 adv;
  logic [15:0]                          ctrl;
  logic [DATA_WIDTH-OPCODE_WIDTH-1:0]   ir_operand;
  logic [STEP_WIDTH-1:0]                step;
  logic                                 halted;

  modport slave (
    input  tick, run_mode, step_req,
    input  bus_in, carry_in, zero_in,
    output adv, ctrl, ir_operand,
    output step, halted
  );

  modport master (
    output tick, run_mode, step_req,
    output bus_in, carry_in, zero_in,
    input  adv, ctrl, ir_operand,
    input  step, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control-word sequencer with IR, flags and step counter.
// Optional early end of empty microsteps: CONTROL_SEQUENCER_EARLY_END_EN.
module control_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_COUNT   = 5,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  control_sequencer_if.slave   cs
);

  localparam int ARGW = DATA_WIDTH - OPCODE_WIDTH;

  localparam logic [15:0] HLT = 16'h8000;
  localparam logic [15:0] MI  = 16'h4000;
  localparam logic [15:0] RI  = 16'h2000;
  localparam logic [15:0] RO  = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800;
  localparam logic [15:0] II  = 16'h0400;
  localparam logic [15:0] AI  = 16'h0200;
  localparam logic [15:0] AO  = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080;
  localparam logic [15:0] SU  = 16'h0040;
  localparam logic [15:0] BI  = 16'h0020;
  localparam logic [15:0] OI  = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008;
  localparam logic [15:0] CO  = 16'h0004;
  localparam logic [15:0] J   = 16'h0002;
  localparam logic [15:0] FI  = 16'h0001;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(15);

  localparam logic [STEP_WIDTH-1:0] LAST =
    STEP_WIDTH'(STEP_COUNT - 1);

  logic [DATA_WIDTH-1:0]   ir;
  logic [STEP_WIDTH-1:0]   step;
  logic [STEP_WIDTH-1:0]   step_next;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    c_flag;
  logic                    z_flag;
  logic                    halted;
  logic                    step_pending;
  logic                    adv;
  logic [15:0]             ctrl;
  logic [15:0]             s2;
  logic [15:0]             s3;
  logic [15:0]             s4;

  assign opcode = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign adv    = cs.tick & ~halted
                & (cs.run_mode | step_pending);

  // Execute-phase microcode; anything not listed is a NOP
  always_comb begin
    s2 = '0;
    s3 = '0;
    s4 = '0;
    unique case (1'b1)
      opcode == OP_LDA: begin
        s2 = IO | MI;
        s3 = RO | AI;
      end
      opcode == OP_ADD: begin
        s2 = IO | MI;
        s3 = RO | BI;
        s4 = EO | AI | FI;
      end
      opcode == OP_SUB: begin
        s2 = IO | MI;
        s3 = RO | BI;
        s4 = EO | AI | SU | FI;
      end
      opcode == OP_STA: begin
        s2 = IO | MI;
        s3 = AO | RI;
      end
      opcode == OP_LDI: s2 = IO | AI;
      opcode == OP_JMP: s2 = IO | J;
      opcode == OP_JC:  s2 = c_flag ? (IO | J) : '0;
      opcode == OP_JZ:  s2 = z_flag ? (IO | J) : '0;
      opcode == OP_OUT: s2 = AO | OI;
      opcode == OP_HLT: s2 = HLT;
      default: ;
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (halted)
      ctrl = HLT;
    else if (step == STEP_WIDTH'(0))
      ctrl = CO | MI;
    else if (step == STEP_WIDTH'(1))
      ctrl = RO | II | CE;
    else if (step == STEP_WIDTH'(2))
      ctrl = s2;
    else if (step == STEP_WIDTH'(3))
      ctrl = s3;
    else if (step == STEP_WIDTH'(4))
      ctrl = s4;
  end

  always_comb begin
    step_next = (step == LAST) ? '0
              : step + STEP_WIDTH'(1);
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
    // Fetch steps always produce a nonzero word, so never skipped
    if (step >= STEP_WIDTH'(2) && ctrl == '0)
      step_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step         <= '0;
      ir           <= '0;
      c_flag       <= 1'b0;
      z_flag       <= 1'b0;
      halted       <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      // A request landing on an advance is consumed by it
      if (adv)
        step_pending <= 1'b0;
      else if (cs.step_req)
        step_pending <= 1'b1;
      if (adv) begin
        step <= step_next;
        if (ctrl[10])
          ir <= cs.bus_in;
        if (ctrl[0]) begin
          c_flag <= cs.carry_in;
          z_flag <= cs.zero_in;
        end
        if (ctrl[15])
          halted <= 1'b1;
      end
    end
  end

  assign cs.adv        = adv;
  assign cs.ctrl       = ctrl;
  assign cs.ir_operand = ir[ARGW-1:0];
  assign cs.step       = step;
  assign cs.halted     = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: every adv pops the
// expected {step, ctrl}; scenario tasks check state inline.
module tb_control_sequencer;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [18:0] exp_q[$];

  control_sequencer_if #(
    .DATA_WIDTH(8),
    .OPCODE_WIDTH(4),
    .STEP_WIDTH(3)
  ) cs ();

  control_sequencer #(
    .DATA_WIDTH(8),
    .OPCODE_WIDTH(4),
    .STEP_COUNT(5),
    .STEP_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cs(cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    logic [18:0] e;
    if (cs.adv === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL adv_seq: unexpected adv step=%0d ctrl=%h",
                 cs.step, cs.ctrl);
      end else begin
        e = exp_q.pop_front();
        if ({cs.step, cs.ctrl} !== e) begin
          fails++;
          $display("FAIL adv_seq: got step=%0d ctrl=%h need step=%0d ctrl=%h",
                   cs.step, cs.ctrl, e[18:16], e[15:0]);
        end
      end
    end
  end

  task automatic pulse(input logic sreq);
    @(posedge clk); #1;
    cs.tick     = 1'b1;
    cs.step_req = sreq;
    @(posedge clk); #1;
    cs.tick     = 1'b0;
    cs.step_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst     = 1'b1;
    cs.tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_adv(input int s, input logic [15:0] c);
    exp_q.push_back({3'(s), c});
  endtask

  task automatic run_instr(input logic [7:0] instr,
                           input logic cin, input logic zin,
                           input logic [15:0] e2,
                           input logic [15:0] e3,
                           input logic [15:0] e4);
    logic [15:0] ex [5];
    ex[0] = 16'h4004;
    ex[1] = 16'h1408;
    ex[2] = e2;
    ex[3] = e3;
    ex[4] = e4;
    cs.bus_in   = instr;
    cs.carry_in = cin;
    cs.zero_in  = zin;
    for (int s = 0; s < 5; s++) begin
      push_adv(s, ex[s]);
      pulse(1'b0);
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
      if (s >= 2 && ex[s] == 16'h0000) break;
`endif
    end
  endtask

  task automatic test_reset();
    cs.tick = 1'b0; cs.run_mode = 1'b1; cs.step_req = 1'b0;
    cs.bus_in = 8'h00; cs.carry_in = 1'b0; cs.zero_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cs.step !== 3'd0 || cs.ctrl !== 16'h4004) begin
      fails++;
      $display("FAIL reset_state: step=%0d ctrl=%h need 0/4004",
               cs.step, cs.ctrl);
    end
    tests++;
    if (cs.adv !== 1'b0 || cs.halted !== 1'b0 ||
        cs.ir_operand !== 4'h0) begin
      fails++;
      $display("FAIL reset_misc: adv=%b halted=%b opnd=%h need 0/0/0",
               cs.adv, cs.halted, cs.ir_operand);
    end
  endtask

  task automatic test_fetch_add();
    apply_reset();
    cs.run_mode = 1'b1;
    cs.bus_in   = 8'h2E;
    push_adv(0, 16'h4004); pulse(1'b0);
    tests++;
    if (cs.step !== 3'd1 || cs.ctrl !== 16'h1408) begin
      fails++;
      $display("FAIL fetch1: step=%0d ctrl=%h need 1/1408",
               cs.step, cs.ctrl);
    end
    push_adv(1, 16'h1408); pulse(1'b0);
    tests++;
    if (cs.ir_operand !== 4'hE || cs.ctrl !== 16'h4800) begin
      fails++;
      $display("FAIL add_s2: opnd=%h ctrl=%h need E/4800",
               cs.ir_operand, cs.ctrl);
    end
    push_adv(2, 16'h4800); pulse(1'b0);
    tests++;
    if (cs.ctrl !== 16'h1020) begin
      fails++;
      $display("FAIL add_s3: ctrl=%h need 1020", cs.ctrl);
    end
    push_adv(3, 16'h1020); pulse(1'b0);
    tests++;
    if (cs.step !== 3'd4 || cs.ctrl !== 16'h0281) begin
      fails++;
      $display("FAIL add_s4: step=%0d ctrl=%h need 4/0281",
               cs.step, cs.ctrl);
    end
    cs.carry_in = 1'b1;
    cs.zero_in  = 1'b0;
    push_adv(4, 16'h0281); pulse(1'b0);
    tests++;
    if (cs.step !== 3'd0 || cs.ctrl !== 16'h4004) begin
      fails++;
      $display("FAIL add_wrap: step=%0d ctrl=%h need 0/4004",
               cs.step, cs.ctrl);
    end
  endtask

  // Flags left by ADD: C=1, Z=0
  task automatic test_cond_jump();
    run_instr(8'h75, 1'b0, 1'b0, 16'h0802, 16'h0, 16'h0);
    tests++;
    if (cs.ir_operand !== 4'h5 || cs.step !== 3'd0) begin
      fails++;
      $display("FAIL jc_taken: opnd=%h step=%0d need 5/0",
               cs.ir_operand, cs.step);
    end
    run_instr(8'h85, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    run_instr(8'h31, 1'b0, 1'b1, 16'h4800, 16'h1020, 16'h02C1);
    run_instr(8'h75, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    run_instr(8'h85, 1'b0, 1'b0, 16'h0802, 16'h0, 16'h0);
    tests++;
    if (cs.step !== 3'd0 || cs.ctrl !== 16'h4004) begin
      fails++;
      $display("FAIL jz_end: step=%0d ctrl=%h need 0/4004",
               cs.step, cs.ctrl);
    end
  endtask

  task automatic test_decode();
    logic [7:0]  ins [8];
    logic [15:0] w2  [8];
    logic [15:0] w3  [8];
    ins = '{8'h03, 8'h1A, 8'h4C, 8'h57, 8'h69, 8'h92, 8'hD1, 8'hE0};
    w2  = '{16'h0000, 16'h4800, 16'h4800, 16'h0A00,
            16'h0802, 16'h0000, 16'h0000, 16'h0110};
    w3  = '{16'h0000, 16'h1200, 16'h2100, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      run_instr(ins[i], 1'b0, 1'b0, w2[i], w3[i], 16'h0);
      tests++;
      if (cs.ir_operand !== ins[i][3:0] || cs.step !== 3'd0) begin
        fails++;
        $display("FAIL decode_%h: opnd=%h step=%0d need %h/0",
                 ins[i], cs.ir_operand, cs.step, ins[i][3:0]);
      end
    end
  endtask

  task automatic test_single_step();
    apply_reset();
    cs.run_mode = 1'b0;
    cs.bus_in   = 8'h00;
    repeat (3) pulse(1'b0);
    tests++;
    if (cs.step !== 3'd0) begin
      fails++;
      $display("FAIL ss_frozen: step=%0d need 0", cs.step);
    end
    @(posedge clk); #1; cs.step_req = 1'b1;
    @(posedge clk); #1; cs.step_req = 1'b0;
    push_adv(0, 16'h4004); pulse(1'b0);
    pulse(1'b0);
    tests++;
    if (cs.step !== 3'd1) begin
      fails++;
      $display("FAIL ss_one: step=%0d need 1", cs.step);
    end
    @(posedge clk); #1; cs.step_req = 1'b1;
    @(posedge clk); #1; cs.step_req = 1'b0;
    push_adv(1, 16'h1408); pulse(1'b1);
    pulse(1'b0);
    pulse(1'b0);
    tests++;
    if (cs.step !== 3'd2) begin
      fails++;
      $display("FAIL ss_coincident: step=%0d need 2", cs.step);
    end
    cs.run_mode = 1'b1;
  endtask

  task automatic test_halt();
    apply_reset();
    cs.run_mode = 1'b1;
    cs.bus_in   = 8'hF0;
    push_adv(0, 16'h4004); pulse(1'b0);
    push_adv(1, 16'h1408); pulse(1'b0);
    push_adv(2, 16'h8000); pulse(1'b0);
    tests++;
    if (cs.halted !== 1'b1 || cs.ctrl !== 16'h8000 ||
        cs.step !== 3'd3) begin
      fails++;
      $display("FAIL halt_enter: h=%b ctrl=%h step=%0d need 1/8000/3",
               cs.halted, cs.ctrl, cs.step);
    end
    repeat (2) pulse(1'b1);
    tests++;
    if (cs.halted !== 1'b1 || cs.step !== 3'd3 ||
        cs.ctrl !== 16'h8000) begin
      fails++;
      $display("FAIL halt_sticky: h=%b ctrl=%h step=%0d need 1/8000/3",
               cs.halted, cs.ctrl, cs.step);
    end
    apply_reset();
    tests++;
    if (cs.halted !== 1'b0 || cs.step !== 3'd0 ||
        cs.ctrl !== 16'h4004) begin
      fails++;
      $display("FAIL halt_clear: h=%b ctrl=%h step=%0d need 0/4004/0",
               cs.halted, cs.ctrl, cs.step);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cs.run_mode = 1'b1;
    cs.bus_in   = 8'h2E;
    cs.carry_in = 1'b1;
    cs.zero_in  = 1'b1;
    push_adv(0, 16'h4004); pulse(1'b0);
    push_adv(1, 16'h1408); pulse(1'b0);
    push_adv(2, 16'h4800); pulse(1'b0);
    push_adv(3, 16'h1020); pulse(1'b0);
    push_adv(4, 16'h0281);
    @(posedge clk); #1;
    rst = 1'b1; cs.tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cs.tick = 1'b0;
    tests++;
    if (cs.step !== 3'd0 || cs.ir_operand !== 4'h0 ||
        cs.ctrl !== 16'h4004) begin
      fails++;
      $display("FAIL rst_mid: step=%0d opnd=%h ctrl=%h need 0/0/4004",
               cs.step, cs.ir_operand, cs.ctrl);
    end
    run_instr(8'h75, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    run_instr(8'h85, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fetch_add();
    test_cond_jump();
    test_decode();
    test_single_step();
    test_halt();
    test_reset_mid();
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL adv_missing: %0d advs outstanding, need 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
